mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port Nx32 BRAM memory block.
- Port 0 is normally instruction fetch; port 1 is normally load/store. Both ports are fully general (read or write).
- Grants one access at a time, round-robin, and drives the memory's active-low strobes for exactly one cycle per access.
- Returns read data with a one-cycle ack pulse. Sits between the soft-core bus masters and the memory.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: FSM states, port selector and
// the last-granted reset value that makes port 0 win the first tie.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef logic port_sel_t;

  localparam port_sel_t RESET_LAST = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle between the two bus masters, mem_arbiter and the single-port BRAM.
// slave = arbiter side, master = requester side, mem = memory side.
interface mem_arbiter_if #(
  parameter int unsigned WORDS      = 6,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  p0_req_i;
  logic                  p0_we_i;
  logic [WORDS-1:0]      p0_addr_i;
  logic [DATA_WIDTH-1:0] p0_wdata_i;
  logic                  p0_ack_o;

  logic                  p1_req_i;
  logic                  p1_we_i;
  logic [WORDS-1:0]      p1_addr_i;
  logic [DATA_WIDTH-1:0] p1_wdata_i;
  logic                  p1_ack_o;

  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  busy_o;

  logic [WORDS-1:0]      mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic                  mem_wr_n_o;
  logic                  mem_rd_n_o;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input  mem_data_i,
    output p0_ack_o, p1_ack_o, rdata_o, busy_o,
    output mem_addr_o, mem_data_o, mem_wr_n_o, mem_rd_n_o
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
    input  p0_ack_o, p1_ack_o, rdata_o, busy_o
  );

  modport mem (
    input  mem_addr_o, mem_data_o, mem_wr_n_o, mem_rd_n_o,
    output mem_data_i
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for two requesters.
// Build option MEM_ARB_FIXED_PRIO_EN: port 0 always wins a tie; otherwise round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  port_sel_t last,
  output port_sel_t winner,
  output logic      valid
);

  always_comb begin
    valid = req0 | req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (req0)      winner = 1'b0;
    else if (req1) winner = 1'b1;
    else           winner = last;
`else
    if (req0 && req1) winner = ~last;
    else if (req0)    winner = 1'b0;
    else if (req1)    winner = 1'b1;
    else              winner = last;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port negedge BRAM: one access per
// 3 cycles, one-cycle active-low strobe, one-cycle ack. Option: MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORDS      = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  mem_arbiter_if.slave  bus
);

  arb_state_t            state_q, state_d;
  port_sel_t             last, win_q, win_d, pick_win;
  logic                  pick_valid;
  logic                  we_q, we_d;
  logic [WORDS-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic                  busy_q;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign last = RESET_LAST;
`else
  always_ff @(posedge clk_i) begin
    if (reset_i)              last <= RESET_LAST;
    else if (state_q == DONE) last <= win_q;
  end
`endif

  mem_arb_pick u_pick (
    .req0   (bus.p0_req_i),
    .req1   (bus.p1_req_i),
    .last   (last),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes and acks default inactive.
  always_comb begin
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d   = pick_win;
          we_d    = pick_win ? bus.p1_we_i    : bus.p0_we_i;
          addr_d  = pick_win ? bus.p1_addr_i  : bus.p0_addr_i;
          wdata_d = pick_win ? bus.p1_wdata_i : bus.p0_wdata_i;
          wr_n_d  = ~we_d;
          rd_n_d  = we_d;
        end
      end
      ACCESS: begin
        if (!we_q) rdata_d = bus.mem_data_i;
        ack0_d = (win_q == 1'b0);
        ack1_d = (win_q == 1'b1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      win_q   <= RESET_LAST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = wdata_q;
  assign bus.mem_wr_n_o = wr_n_q;
  assign bus.mem_rd_n_o = rd_n_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.p0_ack_o   = ack0_q;
  assign bus.p1_ack_o   = ack1_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural negedge BRAM and a reference memory model.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
  localparam int BOUND = 400;
`else
  localparam bit FIXED = 1'b0;
  localparam int BOUND = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORDS(6), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.WORDS(6), .DATA_WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 5) ? 32'h1111_000B : (32'hC0DE_0000 + i);
  endfunction

  // Behavioural single-port BRAM acting on negedge.
  logic [31:0] mem_model [64];
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= init_word(i);
    end else begin
      if (!bus.mem_wr_n_o) mem_model[bus.mem_addr_o] <= bus.mem_data_o;
      if (!bus.mem_rd_n_o) bus.mem_data_i <= mem_model[bus.mem_addr_o];
    end
  end

  // Protocol monitor, sampled mid-cycle.
  int strobe_cnt = 0, ack_cnt = 0, viol = 0;
  always @(negedge clk) begin
    if (!bus.mem_wr_n_o && !bus.mem_rd_n_o) viol++;
    if (bus.p0_ack_o && bus.p1_ack_o) viol++;
    if (!bus.mem_wr_n_o || !bus.mem_rd_n_o) strobe_cnt++;
    ack_cnt += int'(bus.p0_ack_o) + int'(bus.p1_ack_o);
  end

  int passed = 0, total = 0;
  logic [31:0] ref_mem [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: bound expired, got timeout expected completion", name);
  endtask

  task automatic set_port(input bit p, input bit r, input bit we,
                          input logic [5:0] a, input logic [31:0] d);
    if (p) begin
      bus.p1_req_i = r; bus.p1_we_i = we; bus.p1_addr_i = a; bus.p1_wdata_i = d;
    end else begin
      bus.p0_req_i = r; bus.p0_we_i = we; bus.p0_addr_i = a; bus.p0_wdata_i = d;
    end
  endtask

  function automatic logic ack_of(input bit p);
    return p ? bus.p1_ack_o : bus.p0_ack_o;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_access(input bit p, input bit we, input logic [5:0] a, input logic [31:0] d,
                           output int lat, output int rd_lo, output int wr_lo,
                           output int bad, output int other);
    lat = 0; rd_lo = 0; wr_lo = 0; bad = 0; other = 0;
    set_port(p, 1'b1, we, a, d);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (!bus.mem_rd_n_o) begin rd_lo++; if (bus.mem_addr_o !== a) bad++; end
      if (!bus.mem_wr_n_o) begin
        wr_lo++;
        if (bus.mem_addr_o !== a || bus.mem_data_o !== d) bad++;
      end
      if (ack_of(!p)) other++;
      if (ack_of(p)) begin lat = c; break; end
    end
    set_port(p, 1'b0, we, a, d);
    if (lat == 0) fail_now("ack_timeout");
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t tbl [6];
    int lat, rd_lo, wr_lo, bad, other;

    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;

    check("rst_busy",  32'(bus.busy_o),     32'd0);
    check("rst_ack0",  32'(bus.p0_ack_o),   32'd0);
    check("rst_ack1",  32'(bus.p1_ack_o),   32'd0);
    check("rst_wr_n",  32'(bus.mem_wr_n_o), 32'd1);
    check("rst_rd_n",  32'(bus.mem_rd_n_o), 32'd1);
    check("rst_addr",  32'(bus.mem_addr_o), 32'd0);
    check("rst_wdata", bus.mem_data_o,      32'd0);
    check("rst_rdata", bus.rdata_o,         32'd0);

    // Single-port transactions; write rows expect rdata to stay at its previous value.
    tbl[0] = '{1'b0, 1'b0, 6'd5,  32'h0,         32'h1111_000B};
    tbl[1] = '{1'b1, 1'b1, 6'h3F, 32'hDEAD_BEEF, 32'h1111_000B};
    tbl[2] = '{1'b1, 1'b0, 6'h3F, 32'h0,         32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b1, 6'd0,  32'h1234_5678, 32'hDEAD_BEEF};
    tbl[4] = '{1'b0, 1'b0, 6'd0,  32'h0,         32'h1234_5678};
    tbl[5] = '{1'b1, 1'b0, 6'd5,  32'h0,         32'h1111_000B};
    for (int i = 0; i < 6; i++) begin
      do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd_lo, wr_lo, bad, other);
      if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wdata;
      check($sformatf("v%0d_latency", i),   32'(lat),   32'd2);
      check($sformatf("v%0d_rd_cycles", i), 32'(rd_lo), 32'(!tbl[i].we));
      check($sformatf("v%0d_wr_cycles", i), 32'(wr_lo), 32'(tbl[i].we));
      check($sformatf("v%0d_strobe_bus", i), 32'(bad),  32'd0);
      check($sformatf("v%0d_other_ack", i), 32'(other), 32'd0);
      check($sformatf("v%0d_rdata", i),     bus.rdata_o, tbl[i].exp_rdata);
      check($sformatf("v%0d_busy_ack", i),  32'(bus.busy_o), 32'd1);
      tick();
      check($sformatf("v%0d_ack_drop", i),  32'(ack_of(tbl[i].port)), 32'd0);
      check($sformatf("v%0d_idle", i),      32'(bus.busy_o), 32'd0);
    end

    // Contention: both ports hold reads from a freshly reset pointer.
    begin
      int order[$];
      logic [31:0] rds[$];
      int edges = 0, overlap = 0;
      rst = 1'b1; tick(); rst = 1'b0;
      set_port(1'b0, 1'b1, 1'b0, 6'd1, '0);
      set_port(1'b1, 1'b1, 1'b0, 6'd2, '0);
      while (order.size() < 4 && edges < 40) begin
        tick(); edges++;
        if (bus.p0_ack_o && bus.p1_ack_o) overlap++;
        if (bus.p0_ack_o) begin order.push_back(0); rds.push_back(bus.rdata_o); end
        if (bus.p1_ack_o) begin order.push_back(1); rds.push_back(bus.rdata_o); end
      end
      set_port(1'b0, 1'b0, 1'b0, 6'd1, '0);
      set_port(1'b1, 1'b0, 1'b0, 6'd2, '0);
      check("cont_grants", 32'(order.size()), 32'd4);
      check("cont_edges",  32'(edges),        32'd11);
      check("cont_overlap", 32'(overlap),     32'd0);
      for (int i = 0; i < order.size(); i++) begin
        check($sformatf("cont_order%0d", i), 32'(order[i]), FIXED ? 32'd0 : 32'(i % 2));
        check($sformatf("cont_rdata%0d", i), rds[i], ref_mem[(order[i] == 0) ? 1 : 2]);
      end
      repeat (3) tick();
    end

    // Reset during ACCESS aborts the access with no ack.
    begin
      int snap;
      snap = ack_cnt;
      set_port(1'b0, 1'b1, 1'b0, 6'd5, '0);
      tick();
      check("rsta_strobe", 32'(bus.mem_rd_n_o), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_port(1'b0, 1'b0, 1'b0, 6'd5, '0);
      check("rsta_busy", 32'(bus.busy_o),     32'd0);
      check("rsta_rd_n", 32'(bus.mem_rd_n_o), 32'd1);
      check("rsta_wr_n", 32'(bus.mem_wr_n_o), 32'd1);
      check("rsta_ack0", 32'(bus.p0_ack_o),   32'd0);
      repeat (4) tick();
      check("rsta_no_ack", 32'(ack_cnt - snap), 32'd0);
    end

    // Address change during ACCESS must not disturb the latched address.
    begin
      int waited = 0;
      set_port(1'b1, 1'b1, 1'b0, 6'd10, '0);
      tick();
      check("hold_addr_access", 32'(bus.mem_addr_o), 32'd10);
      bus.p1_addr_i = 6'd20;
      while (!bus.p1_ack_o && waited < 10) begin tick(); waited++; end
      if (!bus.p1_ack_o) fail_now("hold_ack");
      set_port(1'b1, 1'b0, 1'b0, 6'd20, '0);
      check("hold_addr_done", 32'(bus.mem_addr_o), 32'd10);
      check("hold_rdata", bus.rdata_o, ref_mem[10]);
      repeat (2) tick();
    end

    // Random traffic against the reference memory.
    begin
      bit pend[2], just[2], we[2];
      logic [5:0] a[2];
      logic [31:0] d[2];
      int age[2];
      int s0, a0, done_cnt = 0, unexp = 0, viol0;
      s0 = strobe_cnt; a0 = ack_cnt; viol0 = viol;
      pend = '{0, 0}; age = '{0, 0};
      for (int cyc = 0; cyc < 1100; cyc++) begin
        tick();
        for (int p = 0; p < 2; p++) begin
          just[p] = 1'b0;
          if (pend[p] && ack_of(p[0])) begin
            if (we[p]) ref_mem[a[p]] = d[p];
            else check("rand_rdata", bus.rdata_o, ref_mem[a[p]]);
            pend[p] = 1'b0; just[p] = 1'b1; done_cnt++;
            set_port(p[0], 1'b0, we[p], a[p], d[p]);
          end else if (ack_of(p[0])) begin
            unexp++;
          end else if (pend[p]) begin
            age[p]++;
            if (age[p] > BOUND) begin
              fail_now($sformatf("rand_liveness_p%0d", p));
              pend[p] = 1'b0;
              set_port(p[0], 1'b0, we[p], a[p], d[p]);
            end
          end
        end
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && !just[p] && cyc < 1000 && $urandom_range(2) == 0) begin
            we[p] = $urandom_range(1) == 1;
            a[p]  = 6'($urandom_range(7));
            d[p]  = $urandom;
            pend[p] = 1'b1; age[p] = 0;
            set_port(p[0], 1'b1, we[p], a[p], d[p]);
          end
        end
      end
      tick();
      check("rand_drained",  32'(int'(pend[0]) + int'(pend[1])), 32'd0);
      check("rand_acks",     32'(ack_cnt - a0),    32'(done_cnt));
      check("rand_strobes",  32'(strobe_cnt - s0), 32'(done_cnt));
      check("rand_unexp",    32'(unexp),           32'd0);
      check("rand_protocol", 32'(viol - viol0),    32'd0);
      check("rand_activity", 32'(done_cnt > 100),  32'd1);
    end

    check("protocol_total", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
